// File: rtl/uart_command_decoder.sv
// ---------------------------------------------------------------------------
// uart_command_decoder
//
// Host-to-device command decoder for the entropy UART link. Decodes bytes
// from the UART receiver into a small command set:
//   'r' (0x72)           request a system reset (one-cycle pulse)
//   'g' (0x67)           free-running stream (no byte budget)
//   's' (0x73)           stop the stream
//   'n' (0x6E) hi lo     stream exactly {hi,lo} bytes, then stop
// Payload bytes of 'n' are raw binary. The payload is abandoned if no byte
// arrives within TIMEOUT_US microseconds.
//
// Optional feature (macro UART_COMMAND_DECODER_ACK_EN): emit an ack byte
// (the opcode, or '?' on error) for every accepted or rejected command.
// Without the macro, ack_valid and ack_byte are tied to zero.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   received      in   one-cycle strobe, rx_byte valid
//   rx_byte       in   received byte
//   recv_error    in   one-cycle strobe, framing error on current byte
//   byte_sent     in   one-cycle strobe, one stream byte handed to uart tx
//   reset_req     out  one-cycle pulse, request system reset
//   stream_en     out  level, stream transmission permitted
//   budget_active out  level, stream limited by byte budget
//   budget        out  remaining byte budget
//   cmd_error     out  one-cycle pulse, rejected or aborted command
//   ack_valid     out  one-cycle pulse, ack byte available
//   ack_byte      out  ack value
// ---------------------------------------------------------------------------
module uart_command_decoder #(
  parameter int CLOCKFRQ   = 32000000,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  input  logic        byte_sent,
  output logic        reset_req,
  output logic        stream_en,
  output logic        budget_active,
  output logic [15:0] budget,
  output logic        cmd_error,
  output logic        ack_valid,
  output logic [7:0]  ack_byte
);

  localparam int TIMEOUT_CYCLES = CLOCKFRQ / 1000000 * TIMEOUT_US;
  localparam int CW             = $clog2(TIMEOUT_CYCLES + 1);
  // The counter fires on the edge where it would step onto TIMEOUT_CYCLES.
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_RESET = 8'h72;
  localparam logic [7:0] OP_GO    = 8'h67;
  localparam logic [7:0] OP_STOP  = 8'h73;
  localparam logic [7:0] OP_COUNT = 8'h6E;

  typedef enum logic [1:0] {
    IDLE,
    GET_HI,
    GET_LO
  } state_t;

  state_t        state, state_n;
  logic [7:0]    hi_byte, hi_byte_n;
  logic [CW-1:0] timer, timer_n;
  logic          reset_req_n, stream_en_n, budget_active_n, cmd_error_n;
  logic [15:0]   budget_n;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  // NOTE: every register, including the payload holding byte, is reset so a
  // reset arriving mid-command leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      hi_byte       <= 8'h00;
      timer         <= '0;
      reset_req     <= 1'b0;
      stream_en     <= 1'b1;
      budget_active <= 1'b0;
      budget        <= 16'h0000;
      cmd_error     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed for this edge, independent of statement order.
      state         <= state_n;
      hi_byte       <= hi_byte_n;
      timer         <= timer_n;
      reset_req     <= reset_req_n;
      stream_en     <= stream_en_n;
      budget_active <= budget_active_n;
      budget        <= budget_n;
      cmd_error     <= cmd_error_n;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode. Lower-priority effects are written first
  // so later, higher-priority branches simply overwrite them.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_n         = state;
    hi_byte_n       = hi_byte;
    timer_n         = timer;
    reset_req_n     = 1'b0;
    stream_en_n     = stream_en;
    budget_active_n = budget_active;
    budget_n        = budget;
    cmd_error_n     = 1'b0;

    // Budget consumption: lowest priority, overridden by stream commands.
    if (byte_sent && budget_active && (budget != 16'h0000)) begin
      budget_n = budget - 16'd1;
      if (budget == 16'd1) begin
        stream_en_n     = 1'b0;
        budget_active_n = 1'b0;
      end
    end

    if (recv_error) begin
      // A corrupted byte aborts whatever was in progress.
      state_n     = IDLE;
      timer_n     = '0;
      cmd_error_n = 1'b1;
    end else if (received) begin
      timer_n = '0;
      unique case (state)
        IDLE: begin
          unique case (rx_byte)
            OP_RESET: reset_req_n = 1'b1;
            OP_GO: begin
              stream_en_n     = 1'b1;
              budget_active_n = 1'b0;
              budget_n        = budget;
            end
            OP_STOP: begin
              stream_en_n     = 1'b0;
              budget_active_n = 1'b0;
              budget_n        = budget;
            end
            OP_COUNT: state_n = GET_HI;
            default:  cmd_error_n = 1'b1;
          endcase
        end
        GET_HI: begin
          hi_byte_n = rx_byte;
          state_n   = GET_LO;
        end
        GET_LO: begin
          // The freshly loaded budget is not reduced by a coincident byte_sent.
          budget_n        = {hi_byte, rx_byte};
          state_n         = IDLE;
          stream_en_n     = ({hi_byte, rx_byte} != 16'h0000);
          budget_active_n = ({hi_byte, rx_byte} != 16'h0000);
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      // Inter-byte gap timer; stream state is left untouched on expiry.
      if (timer == TIMEOUT_LAST) begin
        state_n     = IDLE;
        timer_n     = '0;
        cmd_error_n = 1'b1;
      end else begin
        timer_n = timer + CW'(1);
      end
    end
  end

`ifdef UART_COMMAND_DECODER_ACK_EN
  // -------------------------------------------------------------------------
  // Ack generation: follows the same edge as the command's effect.
  // -------------------------------------------------------------------------
  logic       ack_valid_n;
  logic [7:0] ack_byte_n;

  always_comb begin
    ack_valid_n = 1'b0;
    ack_byte_n  = ack_byte;
    if (cmd_error_n) begin
      ack_valid_n = 1'b1;
      ack_byte_n  = 8'h3F;
    end else if (received && !recv_error) begin
      if (state == IDLE &&
          (rx_byte == OP_RESET || rx_byte == OP_GO || rx_byte == OP_STOP)) begin
        ack_valid_n = 1'b1;
        ack_byte_n  = rx_byte;
      end else if (state == GET_LO) begin
        ack_valid_n = 1'b1;
        ack_byte_n  = OP_COUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_valid <= 1'b0;
      ack_byte  <= 8'h00;
    end else begin
      ack_valid <= ack_valid_n;
      ack_byte  <= ack_byte_n;
    end
  end
`else
  assign ack_valid = 1'b0;
  assign ack_byte  = 8'h00;
`endif

endmodule

// File: tb/tb_uart_command_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_command_decoder
//
// Table-driven bench for uart_command_decoder: each table row is one clock
// of input stimulus plus the output values expected just after that edge.
// Hand-written sequences cover reset values, the inter-byte timeout and a
// reset arriving mid-command. Timeout is shortened to 32 cycles (1 us at
// 32 MHz).
// ---------------------------------------------------------------------------
module tb_uart_command_decoder;

  localparam int CLOCKFRQ   = 32000000;
  localparam int TIMEOUT_US = 1;
  localparam int TO_CYCLES  = 32;

  logic        clk;
  logic        rst;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;
  logic        byte_sent;
  logic        reset_req;
  logic        stream_en;
  logic        budget_active;
  logic [15:0] budget;
  logic        cmd_error;
  logic        ack_valid;
  logic [7:0]  ack_byte;

  uart_command_decoder #(
    .CLOCKFRQ  (CLOCKFRQ),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .received     (received),
    .rx_byte      (rx_byte),
    .recv_error   (recv_error),
    .byte_sent    (byte_sent),
    .reset_req    (reset_req),
    .stream_en    (stream_en),
    .budget_active(budget_active),
    .budget       (budget),
    .cmd_error    (cmd_error),
    .ack_valid    (ack_valid),
    .ack_byte     (ack_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rcv;
    logic [7:0]  b;
    logic        err;
    logic        bs;
    logic        rr;
    logic        se;
    logic        ba;
    logic [15:0] bud;
    logic        ce;
    logic        av;
    logic [7:0]  ab;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock of stimulus: driven on the falling edge, outputs settle #1
  // after the following rising edge.
  task automatic drive(input logic r, input logic [7:0] b, input logic e,
                       input logic s);
    @(negedge clk);
    received   = r;
    rx_byte    = b;
    recv_error = e;
    byte_sent  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic rr, input logic se,
                             input logic ba, input logic [15:0] bud,
                             input logic ce);
    check({tag, " reset_req"},     {31'd0, reset_req},     {31'd0, rr});
    check({tag, " stream_en"},     {31'd0, stream_en},     {31'd0, se});
    check({tag, " budget_active"}, {31'd0, budget_active}, {31'd0, ba});
    check({tag, " budget"},        {16'd0, budget},        {16'd0, bud});
    check({tag, " cmd_error"},     {31'd0, cmd_error},     {31'd0, ce});
  endtask

  task automatic check_ack(input string tag, input logic av,
                           input logic [7:0] ab);
`ifdef UART_COMMAND_DECODER_ACK_EN
    check({tag, " ack_valid"}, {31'd0, ack_valid}, {31'd0, av});
    if (av) check({tag, " ack_byte"}, {24'd0, ack_byte}, {24'd0, ab});
`else
    check({tag, " ack_valid"}, {31'd0, ack_valid}, 32'd0);
    check({tag, " ack_byte"},  {24'd0, ack_byte},  {24'd0, ab & 8'h00});
`endif
  endtask

  function automatic vec_t mk(input logic rcv, input logic [7:0] b,
                              input logic err, input logic bs,
                              input logic rr, input logic se, input logic ba,
                              input logic [15:0] bud, input logic ce,
                              input logic av, input logic [7:0] ab);
    vec_t v;
    v.rcv = rcv; v.b = b; v.err = err; v.bs = bs;
    v.rr = rr; v.se = se; v.ba = ba; v.bud = bud; v.ce = ce;
    v.av = av; v.ab = ab;
    return v;
  endfunction

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b1;
    received   = 1'b0;
    rx_byte    = 8'h00;
    recv_error = 1'b0;
    byte_sent  = 1'b0;

    //                rcv  byte  err  bs   rr  se  ba  budget    ce  av  ack
    // Stop command
    vecs.push_back(mk(1, 8'h73, 0, 0,  0, 0, 0, 16'h0000, 0, 1, 8'h73));
    // 'n' 0x0003 then four sent bytes
    vecs.push_back(mk(1, 8'h6E, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h00, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h03, 0, 0,  0, 1, 1, 16'h0003, 0, 1, 8'h6E));
    vecs.push_back(mk(0, 8'h00, 0, 1,  0, 1, 1, 16'h0002, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 1,  0, 1, 1, 16'h0001, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 1,  0, 0, 0, 16'h0000, 0, 0, 8'h00));
    // 'n' with 0x72 as payload: no reset request
    vecs.push_back(mk(1, 8'h6E, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h72, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h05, 0, 0,  0, 1, 1, 16'h7205, 0, 1, 8'h6E));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 1, 16'h7205, 0, 0, 8'h00));
    // Unknown opcode, framing error, clean reset request
    vecs.push_back(mk(1, 8'h41, 0, 0,  0, 1, 1, 16'h7205, 1, 1, 8'h3F));
    vecs.push_back(mk(1, 8'h72, 1, 0,  0, 1, 1, 16'h7205, 1, 1, 8'h3F));
    vecs.push_back(mk(1, 8'h72, 0, 0,  1, 1, 1, 16'h7205, 0, 1, 8'h72));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 1, 16'h7205, 0, 0, 8'h00));
    // 'n' opcode with byte_sent still decrements the running budget
    vecs.push_back(mk(1, 8'h6E, 0, 1,  0, 1, 1, 16'h7204, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h12, 0, 0,  0, 1, 1, 16'h7204, 0, 0, 8'h00));
    // GET_LO load coincident with byte_sent: load wins, no decrement
    vecs.push_back(mk(1, 8'h02, 0, 1,  0, 1, 1, 16'h1202, 0, 1, 8'h6E));
    vecs.push_back(mk(0, 8'h00, 0, 0,  0, 1, 1, 16'h1202, 0, 0, 8'h00));
    // 's' coincident with byte_sent: command wins; later byte_sent ignored
    vecs.push_back(mk(1, 8'h73, 0, 1,  0, 0, 0, 16'h1202, 0, 1, 8'h73));
    vecs.push_back(mk(0, 8'h00, 0, 1,  0, 0, 0, 16'h1202, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h67, 0, 0,  0, 1, 0, 16'h1202, 0, 1, 8'h67));
    // Zero budget stops the stream
    vecs.push_back(mk(1, 8'h6E, 0, 0,  0, 1, 0, 16'h1202, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h00, 0, 0,  0, 1, 0, 16'h1202, 0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h00, 0, 0,  0, 0, 0, 16'h0000, 0, 1, 8'h6E));
    vecs.push_back(mk(1, 8'h67, 0, 0,  0, 1, 0, 16'h0000, 0, 1, 8'h67));

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    check_ack("reset", 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rcv, vecs[i].b, vecs[i].err, vecs[i].bs);
      check_state($sformatf("v%0d", i), vecs[i].rr, vecs[i].se, vecs[i].ba,
                  vecs[i].bud, vecs[i].ce);
      check_ack($sformatf("v%0d", i), vecs[i].av, vecs[i].ab);
    end

    // Timeout: stop first so the following 'g' has a visible effect.
    drive(1, 8'h73, 0, 0);
    drive(1, 8'h6E, 0, 0);
    drive(1, 8'h01, 0, 0);
    for (int c = 1; c < TO_CYCLES; c++) begin
      drive(0, 8'h00, 0, 0);
      check($sformatf("to wait%0d cmd_error", c), {31'd0, cmd_error}, 32'd0);
    end
    drive(0, 8'h00, 0, 0);
    check_state("to expire", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    check_ack("to expire", 1'b1, 8'h3F);
    drive(0, 8'h00, 0, 0);
    check("to after cmd_error", {31'd0, cmd_error}, 32'd0);
    drive(1, 8'h67, 0, 0);
    check_state("to go", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    check_ack("to go", 1'b1, 8'h67);

    // Reset mid-command returns to IDLE: the next byte is an opcode again.
    drive(1, 8'h6E, 0, 0);
    drive(1, 8'h12, 0, 0);
    @(negedge clk);
    received = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check_state("midrst", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    check_ack("midrst", 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 8'h05, 0, 0);
    check_state("midrst op", 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    drive(0, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
